// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the RV32I integer datapath.
//   - XLEN / REG_ADDR_W / NREGS : architectural register file geometry
//   - REG_ZERO                  : index of the hard-wired zero register x0
//   - regfile_state_t           : register file controller states
//   - RS1_LSB / RS2_LSB / RD_LSB: R-type instruction field positions, used by
//                                 the decoder to slice register indices
// ----------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // CLEAR walks the array writing zeros; RUN serves reads and writebacks.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regfile_state_t;

  // R-type instruction field LSB positions (each field is REG_ADDR_W wide).
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

endpackage : rv_pkg

// File: rtl/regfile_bypass_rv.sv
// ----------------------------------------------------------------------------
// regfile_bypass_rv
// Operand selection for one read port of the register file. Purely
// combinational; one instance per read port.
//
// Ports:
//   idx      in  AW    source register index for this port
//   word     in  XLEN  array contents at idx
//   wr_fire  in  1     a writeback handshake completes this cycle
//   wb_rd    in  AW    writeback destination index
//   wb_data  in  XLEN  writeback data
//   operand  out XLEN  value the port should load at the next edge
//
// Priority: x0 always reads zero; otherwise a same-cycle write to the same
// index wins over the stored word (write-first), so a dependent instruction
// issued alongside the writeback sees the new value.
// ----------------------------------------------------------------------------
module regfile_bypass_rv #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   idx,
  input  logic [XLEN-1:0] word,
  input  logic            wr_fire,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] operand
);

  always_comb begin
    if (idx == '0) begin
      operand = '0;
    end else if (wr_fire && (wb_rd == idx)) begin
      operand = wb_data;
    end else begin
      operand = word;
    end
  end

endmodule : regfile_bypass_rv

// File: rtl/regfile_rv.sv
// ----------------------------------------------------------------------------
// regfile_rv
// Integer register file for the RV32I core: two registered read ports and one
// valid/ready writeback port. After reset the array is cleared one word per
// cycle (NREGS cycles) instead of resetting every word in parallel; traffic is
// refused until that sequence finishes.
//
// Ports:
//   clock            in  1     core clock, rising edge
//   reset            in  1     synchronous, active-high reset
//   enable           in  1     read request: sample rs1/rs2 this cycle
//   rs1, rs2         in  AW    source register indices
//   register_data_1  out XLEN  registered operand for rs1
//   register_data_2  out XLEN  registered operand for rs2
//   read_valid       out 1     operands were updated at the last edge
//   wb_valid         in  1     writeback request
//   wb_rd            in  AW    writeback destination index
//   wb_data          in  XLEN  writeback data
//   wb_ready         out 1     writeback accepted (RUN state)
//   init_done        out 1     clear sequence finished (RUN state)
// ----------------------------------------------------------------------------
module regfile_rv #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int NREGS = rv_pkg::NREGS,
  parameter int AW    = rv_pkg::REG_ADDR_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] register_data_1,
  output logic [XLEN-1:0] register_data_2,
  output logic            read_valid,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_ready,
  output logic            init_done
);

  import rv_pkg::*;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  regfile_state_t  state_q,    state_d;
  logic [AW-1:0]   clr_cnt_q,  clr_cnt_d;
  logic [XLEN-1:0] rdata1_q,   rdata1_d;
  logic [XLEN-1:0] rdata2_q,   rdata2_d;
  logic            rvalid_q,   rvalid_d;

  logic [XLEN-1:0] mem_q [NREGS];

  // Single array write port, shared by the clear sequence and writeback.
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  logic            wb_fire;
  logic [XLEN-1:0] operand_1;
  logic [XLEN-1:0] operand_2;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  // --------------------------------------------------------------------------
  // Handshake / status: straight decodes of the state register.
  // --------------------------------------------------------------------------
  assign wb_ready  = (state_q == RUN);
  assign init_done = (state_q == RUN);
  assign wb_fire   = wb_valid && wb_ready;

  // --------------------------------------------------------------------------
  // Read-port operand selection (x0 and write-first bypass).
  // --------------------------------------------------------------------------
  regfile_bypass_rv #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_bypass_1 (
    .idx     (rs1),
    .word    (mem_q[rs1]),
    .wr_fire (wb_fire),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .operand (operand_1)
  );

  regfile_bypass_rv #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_bypass_2 (
    .idx     (rs2),
    .word    (mem_q[rs2]),
    .wr_fire (wb_fire),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .operand (operand_2)
  );

  // --------------------------------------------------------------------------
  // Next-state / datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch can be inferred.
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rdata1_d  = rdata1_q;
    rdata2_d  = rdata2_q;
    rvalid_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wb_rd;
    mem_wdata = wb_data;

    unique case (state_q)
      CLEAR: begin
        // Reads and writebacks are ignored; zero one word per cycle.
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        if (clr_cnt_q == LAST_IDX) begin
          // Leaving here means the counter never has to wrap.
          state_d = RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      RUN: begin
        // Writes to x0 complete the handshake but never touch the array.
        mem_we = wb_fire && (wb_rd != '0);
        if (enable) begin
          rdata1_d = operand_1;
          rdata2_d = operand_2;
          rvalid_d = 1'b1;
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Register array
  // --------------------------------------------------------------------------
  // NOTE: the array has no reset term; the CLEAR sequence zeroes it, which
  // keeps it mappable to plain storage without a per-word reset network.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign register_data_1 = rdata1_q;
  assign register_data_2 = rdata2_q;
  assign read_valid      = rvalid_q;

endmodule : regfile_rv

// File: tb/tb_regfile_rv.sv
// ----------------------------------------------------------------------------
// tb_regfile_rv
// Directed bench for regfile_rv. A behavioural model predicts each read
// result when the request is driven and queues it; the queue is popped when
// read_valid is expected after the edge.
// ----------------------------------------------------------------------------
module tb_regfile_rv;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef struct {
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
  } exp_t;

  logic            clock;
  logic            reset;
  logic            enable;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] register_data_1;
  logic [XLEN-1:0] register_data_2;
  logic            read_valid;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_ready;
  logic            init_done;

  regfile_rv #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .rs1             (rs1),
    .rs2             (rs2),
    .register_data_1 (register_data_1),
    .register_data_2 (register_data_2),
    .read_valid      (read_valid),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .wb_ready        (wb_ready),
    .init_done       (init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state
  logic [XLEN-1:0] exp_mem [NREGS];
  logic            m_run;
  int              m_cnt;
  exp_t            held;
  exp_t            sb [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [XLEN-1:0] predict(input logic [AW-1:0] idx,
                                              input logic fire,
                                              input logic [AW-1:0] wrd,
                                              input logic [XLEN-1:0] wd);
    if (idx == 0) return '0;
    if (fire && wrd == idx) return wd;
    return exp_mem[idx];
  endfunction

  // One clock cycle: drive, predict, edge, update model, compare.
  task automatic tick(input logic rst, input logic en,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic wv, input logic [AW-1:0] wrd,
                      input logic [XLEN-1:0] wd);
    logic fire;
    logic exp_valid;
    exp_t e;
    reset    = rst;
    enable   = en;
    rs1      = r1;
    rs2      = r2;
    wb_valid = wv;
    wb_rd    = wrd;
    wb_data  = wd;
    fire      = !rst && m_run && wv;
    exp_valid = !rst && m_run && en;
    if (exp_valid) begin
      e.d1 = predict(r1, fire, wrd, wd);
      e.d2 = predict(r2, fire, wrd, wd);
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    if (rst) begin
      m_run   = 1'b0;
      m_cnt   = 0;
      held.d1 = '0;
      held.d2 = '0;
    end else if (!m_run) begin
      exp_mem[m_cnt] = '0;
      if (m_cnt == NREGS - 1) m_run = 1'b1;
      else m_cnt++;
    end else if (fire && wrd != 0) begin
      exp_mem[wrd] = wd;
    end
    if (exp_valid) begin
      if (sb.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        held = sb.pop_front();
      end
    end
    check("read_valid", {31'd0, read_valid}, {31'd0, exp_valid});
    check("rdata1", register_data_1, held.d1);
    check("rdata2", register_data_2, held.d2);
    check("init_done", {31'd0, init_done}, {31'd0, m_run});
    check("wb_ready", {31'd0, wb_ready}, {31'd0, m_run});
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Counts cycles until init_done rises, bounded.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 64) begin
      idle();
      n++;
    end
    check(tag, n, 32);
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) exp_mem[i] = 'x;
    m_run   = 1'b0;
    m_cnt   = 0;
    held.d1 = '0;
    held.d2 = '0;
    reset = 1'b1; enable = 1'b0; rs1 = '0; rs2 = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

    // 1. Reset clear sequence and all-zero contents
    tick(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    wait_init("clear_len");
    for (int k = 0; k < NREGS; k++) tick(1'b0, 1'b1, AW'(k), AW'(k), 1'b0, '0, '0);
    idle();

    // 2. Basic write then read
    tick(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, '0, '0);
    idle();
    idle();

    // 3. x0 protection
    tick(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h12345678);
    tick(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, '0, '0);

    // 4. Write-first bypass, then bypass to x0
    tick(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5);
    tick(1'b0, 1'b1, 5'd0, 5'd7, 1'b1, 5'd0, 32'h5A5A5A5A);
    tick(1'b0, 1'b1, 5'd7, 5'd0, 1'b0, '0, '0);

    // 5. Hold while disabled, re-enable picks up new contents
    tick(1'b0, 1'b0, '0, '0, 1'b1, 5'd1, 32'h11);
    tick(1'b0, 1'b1, 5'd1, 5'd1, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 5'd1, 5'd1, 1'b1, 5'd1, 32'h22);
    tick(1'b0, 1'b1, 5'd1, 5'd2, 1'b0, '0, '0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
           AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 31)), $urandom());
    end

    // 6a. Reset mid-CLEAR restarts the full clear
    tick(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) idle();
    tick(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    wait_init("clear_len_restart");

    // 6b. Reset in RUN re-clears; writes during CLEAR are dropped
    tick(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 32'h55);
    tick(1'b0, 1'b1, 5'd3, 5'd0, 1'b0, '0, '0);
    tick(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < NREGS; i++) begin
      tick(1'b0, 1'b1, 5'd3, 5'd9, 1'b1, 5'd3, 32'hC0DE0000 | 32'(i));
    end
    tick(1'b0, 1'b1, 5'd3, 5'd9, 1'b0, '0, '0);
    check("reg3_after_reclear", register_data_1, 32'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_regfile_rv
